program_counter_unit: RTL
=========================

Name: program_counter_unit

Overview:
- Parametrised next-generation program counter for the RISC-V datapath. Holds the fetch PC and presents it to instruction memory with a valid/ready handshake.
- Selects the next PC by priority: trap, trap return, branch/jump redirect, then sequential advance.
- Saves the exception PC (EPC). Provides a halt/resume run-control state machine.
- Sits between the next-PC control logic and the instruction memory.

Parameters:
- XLEN, 32, width of PC, targets and EPC.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap.
- STEP, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low target bits that must be zero.

Ports:
- clock  input  1  rising-edge clock from datapath
- reset  input  1  asynchronous, active-low reset (0 = reset)
- stall  input  1  pipeline stall; blocks sequential advance only
- fetch_ready  input  1  instruction memory accepts current pc
- branch_taken  input  1  redirect request
- branch_target  input  XLEN  redirect destination
- trap  input  1  exception/interrupt request
- trap_return  input  1  return-from-trap (mret) request
- halt  input  1  enter HALT
- resume  input  1  leave HALT
- pc  output  XLEN  current fetch PC
- pc_valid  output  1  pc is a valid fetch request
- epc  output  XLEN  saved exception PC
- misaligned  output  1  one-cycle pulse: misaligned redirect converted to trap
- state  output  2  00 IDLE, 01 RUN, 10 HALT

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, also mid-operation):
  - pc=RESET_VECTOR, epc=0, state=IDLE, pc_valid=0, misaligned=0.
- IDLE:
  - First rising edge with reset=1 moves to RUN. pc unchanged. All requests in this cycle are ignored.
- RUN:
  - pc_valid=1.
  - Next-PC evaluation each rising edge, first match wins:
    1. trap=1: epc<=pc, pc<=TRAP_VECTOR.
    2. trap_return=1: pc<=epc, epc unchanged.
    3. branch_taken=1 and branch_target[ALIGN_BITS-1:0]!=0: handled as trap (epc<=pc, pc<=TRAP_VECTOR). misaligned=1 for the following cycle.
    4. branch_taken=1 (aligned): pc<=branch_target.
    5. fetch_ready=1 and stall=0: pc<=pc+STEP, truncated to XLEN bits (wraps from 2^XLEN-STEP to 0).
    6. Otherwise: pc holds.
  - Cases 1-4 apply regardless of stall and fetch_ready; a redirect is never lost.
  - halt=1 moves to HALT at the same edge; the next-PC evaluation still applies on that edge.
- HALT:
  - pc_valid=0.
  - pc and epc hold; trap, trap_return and branch_taken are ignored.
  - resume=1 moves to RUN at the next edge, with pc unchanged.
  - halt and resume both asserted in HALT: resume wins.
- misaligned:
  - Registered. 1 only in the cycle after a case-3 event, otherwise 0.
- Latency:
  - pc reflects a request one edge after the request is sampled. No combinational path from inputs to pc.
- state encoding 11 is unreachable. If entered, the next edge returns to IDLE.

Test Plan:
- Reset then release: pc=0x00000000, pc_valid=0 in IDLE. Then RUN. With fetch_ready=1, stall=0 for 3 cycles: pc=0x4, 0x8, 0xC.
- Stall and fetch_ready: stall=1 for 2 cycles -> pc holds at 0xC. fetch_ready=0 -> pc holds. Release -> 0x10.
- Redirects: at pc=0x10, branch_taken=1, target=0x200 -> pc=0x200. Repeat with target=0x202 -> pc=0x100, epc=0x200, misaligned=1 for exactly one cycle.
- Priority and trap return: at pc=0x40, trap=1, trap_return=1 and branch_taken=1 together -> pc=0x100, epc=0x40. Next, trap_return=1 -> pc=0x40.
- Halt and wrap: at pc=0x50, halt=1 -> HALT, pc_valid=0, branch to 0x300 ignored. resume=1 -> RUN with pc=0x54. Force pc via branch to 0xFFFFFFFC, then advance -> pc=0x00000000.
- Asynchronous reset mid-run: assert reset=0 between clock edges -> pc=0x0, epc=0, state=IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/program_counter_unit.sv
// Fetch program counter with trap/trap-return/redirect priority, EPC capture
// and an IDLE/RUN/HALT run-control state machine.
module program_counter_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
  parameter int unsigned     STEP         = 4,
  parameter int unsigned     ALIGN_BITS   = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            trap,
  input  logic            trap_return,
  input  logic            halt,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc,
  output logic            misaligned,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_BAD  = 2'b11
  } state_e;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            mis_q, mis_d;
  logic            target_misaligned;

  assign target_misaligned = |(branch_target & ALIGN_MASK);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    mis_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN: begin
        // Redirects ignore stall/fetch_ready so none is ever dropped.
        if (trap) begin
          epc_d = pc_q;
          pc_d  = TRAP_VECTOR;
        end else if (trap_return) begin
          pc_d = epc_q;
        end else if (branch_taken && target_misaligned) begin
          epc_d = pc_q;
          pc_d  = TRAP_VECTOR;
          mis_d = 1'b1;
        end else if (branch_taken) begin
          pc_d = branch_target;
        end else if (fetch_ready && !stall) begin
          pc_d = pc_q + STEP_INC;
        end
        if (halt) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign misaligned = mis_q;
  assign pc_valid   = (state_q == ST_RUN);
  assign state      = state_q;

endmodule
